jk_ubus_slave_mem: RTL
======================

// Module: jk_ubus_slave_mem
// PURPOSE
// - Synthesisable UBUS slave device. Sits directly downstream of the UBUS slave interface and
//   consumes its address/control; it produces the response signals (wait_state, error, data).
// - Byte-addressed RAM window at ADDR_BASE, with programmable per-beat wait states.
// - Supports 1/2/4/8-byte transfers, one byte per data-phase beat.
// PARAMETERS
// - ADDR_BASE    16'h0000  first byte address claimed by this slave
// - ADDR_SIZE    256       window size in bytes; power of 2, 2..65536
// - WAIT_CYCLES  0         wait-state cycles inserted before every beat, 0..15
// PORTS
// - clk         in   1   bus clock; all logic on posedge
// - reset       in   1   synchronous, active-high
// - addr        in   16  start address, valid in address phase
// - size        in   2   transfer length: 0=1, 1=2, 2=4, 3=8 bytes
// - read        in   1   address phase, read request
// - write       in   1   address phase, write request
// - bip         in   1   burst in progress: 1 on every beat except the last
// - data_in     in   8   write data from master
// - data_out    out  8   read data to master
// - data_oe     out  1   data_out drive enable (tristate control at top level)
// - wait_state  out  1   slave stall for the current beat
// - error       out  1   error response for the current beat
// BEHAVIOUR
// - Reset: data_out=0, data_oe=0, wait_state=0, error=0; FSM=IDLE; beat/wait counters=0.
//   RAM contents are not reset. Reset during a transfer aborts it in the same cycle.
// - Address phase: a cycle in IDLE with read|write=1. Sample addr, size, read, write at that edge.
//   len = 1<<size.
// - Decode: start hit = ADDR_BASE <= addr < ADDR_BASE+ADDR_SIZE.
//   - Start miss: ignore the transfer. Stay in IDLE and drive nothing.
//   - Start hit and (addr+len-1) beyond window, or read&write both 1: ERR transfer.
//   - Otherwise: OK transfer.
//   - Window arithmetic uses 17 bits, so no 16-bit wrap.
// - FSM states:
//   - IDLE -> WAIT when claimed and WAIT_CYCLES>0; IDLE -> BEAT when claimed and WAIT_CYCLES==0.
//   - WAIT: wait_state=1, data_oe=0, error=0. Stay for WAIT_CYCLES cycles, then go to BEAT.
//   - BEAT: wait_state=0; one byte transfers this cycle.
//     - Not last beat: go to WAIT (or BEAT if WAIT_CYCLES==0).
//     - Last beat (beat index = len-1): go to IDLE.
// - Timing: address phase at cycle T. With WAIT_CYCLES=0, beat k is cycle T+1+k.
//   In general, beat k is cycle T+1+k*(WAIT_CYCLES+1)+WAIT_CYCLES.
// - Byte address for beat k = addr+k.
// - OK read: data_out = mem[addr+k-ADDR_BASE], data_oe=1, only in BEAT cycles. Data is
//   registered, with the RAM read indexed from the next-state address.
// - OK write: mem[addr+k-ADDR_BASE] <= data_in at the end of the BEAT cycle.
// - ERR transfer: error=1 in every BEAT cycle. No RAM write. Reads drive data_out=0, data_oe=1.
// - bip is not used for sequencing (length comes from size). Mismatch (bip=1 on the last beat,
//   or bip=0 earlier) is tolerated and flagged only via the stats feature.
// - read/write asserted outside IDLE is ignored; there are no overlapping transfers.
// - data_oe=0 and error=0 in every cycle that is not a BEAT cycle.
// CONFIGURATION
// - JK_UBUS_SLAVE_MEM_STATS_EN defined: adds output ports rd_cnt[15:0], wr_cnt[15:0],
//   err_cnt[15:0] and bip_err_cnt[15:0].
//   - Each counter resets to 0 and saturates at 16'hFFFF.
//   - rd_cnt/wr_cnt increment once per completed OK transfer, on its last beat.
//   - err_cnt increments once per completed ERR transfer.
//   - bip_err_cnt increments per beat with a bip mismatch.
// - Undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
// - Reset, then idle for 5 cycles -> all outputs 0; no response to bus idle.
// - WAIT_CYCLES=0: write size=2 addr=16'h0010 data 11,22,33,44, then read the same location
//   -> read beats at T+1..T+4 return 11,22,33,44; wait_state=0 and error=0 throughout.
// - WAIT_CYCLES=2: read size=0 addr=16'h0005 -> wait_state=1 at T+1,T+2; beat with data at T+3.
// - Overrun: write size=3 addr=ADDR_BASE+ADDR_SIZE-4 -> error=1 on all 8 beats; following
//   reads show RAM unchanged.
// - Miss: read addr=16'h8000 with window 16'h0000/256 -> data_oe, wait_state and error stay 0.
// - Reset asserted on beat 1 of a 4-byte write -> next cycle outputs=0 and FSM idle; only byte 0
//   written. STATS_EN build: wr_cnt not incremented.

Source files
------------

// File: rtl/jk_ubus_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : jk_ubus_slave_mem
// Brief    : UBUS slave byte-RAM window with programmable per-beat wait states.
//            Optional statistics counters when JK_UBUS_SLAVE_MEM_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module jk_ubus_slave_mem #(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter int          ADDR_SIZE   = 256,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [1:0]  size,
  input  logic        read,
  input  logic        write,
  input  logic        bip,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        wait_state,
  output logic        error
`ifdef JK_UBUS_SLAVE_MEM_STATS_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] bip_err_cnt
`endif
);

  localparam int              c_AW       = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;
  localparam logic [16:0]     c_BASE17   = {1'b0, ADDR_BASE};
  localparam logic [16:0]     c_END17    = c_BASE17 + 17'(ADDR_SIZE);
  localparam logic [3:0]      c_WAIT_M1  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit              c_HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [c_AW-1:0] c_IDX_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BEAT = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_AW-1:0] r_idx;
  logic [2:0]      r_beat;
  logic [2:0]      r_len_m1;
  logic [3:0]      r_wcnt;
  logic            r_err;
  logic            r_rd;
  logic            r_wr;
  logic [7:0]      r_data_out;
  logic            r_data_oe;
  logic            r_wait;
  logic            r_error;
  logic [7:0]      r_mem [ADDR_SIZE];

  logic [2:0]      w_len_m1;
  logic [16:0]     w_addr17;
  logic [16:0]     w_last17;
  logic            w_hit;
  logic            w_claim;
  logic            w_xfer_err;
  logic [c_AW-1:0] w_off;
  logic            w_is_last;
  logic            w_beat_err;
  logic            w_beat_rd;
  logic [c_AW-1:0] w_rd_idx;
  logic [7:0]      w_beat_data;

  // Window checks in 17 bits so a start near 16'hFFFF cannot wrap into range.
  always_comb begin
    w_len_m1 = 3'd0;
    case (size)
      2'd0: w_len_m1 = 3'd0;
      2'd1: w_len_m1 = 3'd1;
      2'd2: w_len_m1 = 3'd3;
      default: w_len_m1 = 3'd7;
    endcase
    w_addr17   = {1'b0, addr};
    w_last17   = w_addr17 + {14'd0, w_len_m1};
    w_hit      = (w_addr17 >= c_BASE17) && (w_addr17 < c_END17);
    w_claim    = (read || write) && w_hit;
    w_xfer_err = (w_last17 >= c_END17) || (read && write);
    w_off      = addr[c_AW-1:0] - ADDR_BASE[c_AW-1:0];
    w_is_last  = (r_beat == r_len_m1);
    w_beat_err = (r_state == S_IDLE) ? w_xfer_err : r_err;
    w_beat_rd  = (r_state == S_IDLE) ? read : r_rd;
    // Index of the byte the next BEAT cycle will present.
    if (r_state == S_IDLE)
      w_rd_idx = w_off;
    else if (r_state == S_BEAT)
      w_rd_idx = r_idx + c_IDX_ONE;
    else
      w_rd_idx = r_idx;
    w_beat_data = (w_beat_rd && !w_beat_err) ? r_mem[w_rd_idx] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_beat     <= 3'd0;
      r_len_m1   <= 3'd0;
      r_wcnt     <= 4'd0;
      r_err      <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_data_out <= 8'h00;
      r_data_oe  <= 1'b0;
      r_wait     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_data_out <= 8'h00;
      r_data_oe  <= 1'b0;
      r_wait     <= 1'b0;
      r_error    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_claim) begin
            r_idx    <= w_off;
            r_beat   <= 3'd0;
            r_len_m1 <= w_len_m1;
            r_err    <= w_xfer_err;
            r_rd     <= read;
            r_wr     <= write;
            if (c_HAS_WAIT) begin
              r_state <= S_WAIT;
              r_wait  <= 1'b1;
              r_wcnt  <= c_WAIT_M1;
            end else begin
              r_state    <= S_BEAT;
              r_error    <= w_beat_err;
              r_data_oe  <= w_beat_rd;
              r_data_out <= w_beat_data;
            end
          end
        end
        S_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_state    <= S_BEAT;
            r_error    <= w_beat_err;
            r_data_oe  <= w_beat_rd;
            r_data_out <= w_beat_data;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
            r_wait <= 1'b1;
          end
        end
        S_BEAT: begin
          r_beat <= r_beat + 3'd1;
          r_idx  <= r_idx + c_IDX_ONE;
          if (w_is_last) begin
            r_state <= S_IDLE;
          end else if (c_HAS_WAIT) begin
            r_state <= S_WAIT;
            r_wait  <= 1'b1;
            r_wcnt  <= c_WAIT_M1;
          end else begin
            r_error    <= w_beat_err;
            r_data_oe  <= w_beat_rd;
            r_data_out <= w_beat_data;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM is not reset; a reset on a beat edge suppresses that beat's write.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_BEAT) && r_wr && !r_err)
      r_mem[r_idx] <= data_in;
  end

  assign data_out   = r_data_out;
  assign data_oe    = r_data_oe;
  assign wait_state = r_wait;
  assign error      = r_error;

`ifdef JK_UBUS_SLAVE_MEM_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;
  logic [15:0] r_err_cnt;
  logic [15:0] r_bip_cnt;
  logic        w_bip_bad;

  // bip should be high on every beat except the last.
  assign w_bip_bad = (r_state == S_BEAT) && (bip == w_is_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt  <= 16'd0;
      r_wr_cnt  <= 16'd0;
      r_err_cnt <= 16'd0;
      r_bip_cnt <= 16'd0;
    end else begin
      if ((r_state == S_BEAT) && w_is_last) begin
        if (r_err) begin
          if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end else if (r_rd) begin
          if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
        end else begin
          if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
      end
      if (w_bip_bad && (r_bip_cnt != 16'hFFFF))
        r_bip_cnt <= r_bip_cnt + 16'd1;
    end
  end

  assign rd_cnt      = r_rd_cnt;
  assign wr_cnt      = r_wr_cnt;
  assign err_cnt     = r_err_cnt;
  assign bip_err_cnt = r_bip_cnt;
`else
  logic w_unused_bip;
  assign w_unused_bip = bip;
`endif

endmodule
`default_nettype wire
